// File: rtl/circle_pkg.sv
// Shared types for the midpoint-circle rasteriser: FSM state, octant index,
// and the signed width used for coordinate/offset arithmetic.
package circle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [2:0] octant_t;

    // Two guard bits above the widest operand keep cx+ox and cx-ox free of wrap.
    function automatic int coord_width(input int xw, input int yw, input int rw);
        int m;
        m = xw;
        if (yw > m) m = yw;
        if (rw > m) m = rw;
        return m + 2;
    endfunction

    localparam int COORD_W = coord_width(8, 7, 7);

endpackage

// File: rtl/circle_plotter_if.sv
// Control and pixel-port bundle between a host and circle_plotter.
// slave: the plotter side; master: the host side.
interface circle_plotter_if #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int RW = 7,
    parameter int CW = 3
);
    logic          start;
    logic [XW-1:0] centre_x;
    logic [YW-1:0] centre_y;
    logic [RW-1:0] radius;
    logic [CW-1:0] colour_inp;
    logic          busy;
    logic          done;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;

    modport master (
        output start, centre_x, centre_y, radius, colour_inp,
        input  busy, done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, centre_x, centre_y, radius, colour_inp,
        output busy, done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/circle_octant_mux.sv
// Selects one of the eight symmetric candidate pixels for octant index k
// and flags whether it lies on screen.
module circle_octant_mux
    import circle_pkg::*;
#(
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int SW    = COORD_W
) (
    input  logic [XW-1:0]        cx,
    input  logic [YW-1:0]        cy,
    input  logic signed [SW-1:0] ox,
    input  logic signed [SW-1:0] oy,
    input  octant_t              k,
    output logic [XW-1:0]        x,
    output logic [YW-1:0]        y,
    output logic                 in_bounds
);
    localparam logic signed [SW-1:0] H_LIM = SW'(H_RES);
    localparam logic signed [SW-1:0] V_LIM = SW'(V_RES);

    logic signed [SW-1:0] cxs, cys, px, py;

    assign cxs = SW'($signed({1'b0, cx}));
    assign cys = SW'($signed({1'b0, cy}));

    // octant selection
    always_comb begin
        px = cxs;
        py = cys;
        case (k)
            3'd0: begin px = cxs + ox; py = cys + oy; end
            3'd1: begin px = cxs + oy; py = cys + ox; end
            3'd2: begin px = cxs - ox; py = cys + oy; end
            3'd3: begin px = cxs - oy; py = cys + ox; end
            3'd4: begin px = cxs - ox; py = cys - oy; end
            3'd5: begin px = cxs - oy; py = cys - ox; end
            3'd6: begin px = cxs + ox; py = cys - oy; end
            default: begin px = cxs + oy; py = cys - ox; end
        endcase
    end

    assign in_bounds = !px[SW-1] && (px < H_LIM) && !py[SW-1] && (py < V_LIM);
    assign x = px[XW-1:0];
    assign y = py[YW-1:0];

endmodule

// File: rtl/circle_plotter.sv
// Midpoint-circle rasteriser driving the VGA adapter pixel port.
// Centre, radius and colour are captured on an accepted start; one candidate
// pixel per cycle, off-screen candidates keep their cycle but do not strobe.
// Optional build macro CIRCLE_CLEAR_EN: raster-clear the whole screen to
// colour 0 before drawing.
//
// state    | meaning
// ST_IDLE  | waiting for start (ignored while the done pulse is out)
// ST_CLEAR | screen clear scan, one pixel per cycle (CIRCLE_CLEAR_EN only)
// ST_DRAW  | emitting octant candidates, step update on k=7
// ST_DONE  | drawing finished; raise done, drop busy
module circle_plotter
    import circle_pkg::*;
#(
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int RW    = 7,
    parameter int CW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    circle_plotter_if.slave bus
);
    localparam int SW  = coord_width(XW, YW, RW);
    localparam int CRW = RW + 3;
    localparam logic signed [CRW-1:0] CRIT_ZERO = '0;
    localparam logic signed [CRW-1:0] CRIT_ONE  = CRW'(1);
    localparam logic signed [SW-1:0]  OFS_ONE   = SW'(1);
    localparam octant_t               K_LAST    = 3'd7;

    state_t               state;
    logic [XW-1:0]        cx;
    logic [YW-1:0]        cy;
    logic [CW-1:0]        colour;
    logic signed [SW-1:0] ox, oy;
    logic signed [CRW-1:0] crit;
    octant_t              k;

    logic                 busy_q, done_q, plot_q;
    logic [XW-1:0]        vx_q;
    logic [YW-1:0]        vy_q;
    logic [CW-1:0]        vc_q;

    logic [XW-1:0]        cand_x;
    logic [YW-1:0]        cand_y;
    logic                 cand_in;

    logic signed [SW-1:0]  ox_nx, oy_nx;
    logic signed [CRW-1:0] crit_nx, ox_c, oy_c;
    logic                  more;

`ifdef CIRCLE_CLEAR_EN
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
    logic [XW-1:0] clr_x;
    logic [YW-1:0] clr_y;
`endif

    circle_octant_mux #(
        .H_RES(H_RES), .V_RES(V_RES), .XW(XW), .YW(YW), .SW(SW)
    ) u_mux (
        .cx(cx), .cy(cy), .ox(ox), .oy(oy), .k(k),
        .x(cand_x), .y(cand_y), .in_bounds(cand_in)
    );

    // midpoint step: next offsets, decision variable and loop test
    always_comb begin
        oy_nx   = oy + OFS_ONE;
        ox_nx   = ox;
        oy_c    = CRW'(oy_nx);
        ox_c    = CRW'(ox);
        crit_nx = crit + oy_c + oy_c + CRIT_ONE;
        if (crit > CRIT_ZERO) begin
            ox_nx   = ox - OFS_ONE;
            ox_c    = CRW'(ox_nx);
            crit_nx = crit + oy_c + oy_c - ox_c - ox_c + CRIT_ONE;
        end
        more = (oy_nx <= ox_nx);
    end

    // sequencer with registered pixel port and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cx     <= '0;
            cy     <= '0;
            colour <= '0;
            ox     <= '0;
            oy     <= '0;
            crit   <= '0;
            k      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            plot_q <= 1'b0;
            vx_q   <= '0;
            vy_q   <= '0;
            vc_q   <= '0;
`ifdef CIRCLE_CLEAR_EN
            clr_x  <= '0;
            clr_y  <= '0;
`endif
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !done_q) begin
                        cx     <= bus.centre_x;
                        cy     <= bus.centre_y;
                        colour <= bus.colour_inp;
                        ox     <= SW'($signed({1'b0, bus.radius}));
                        oy     <= '0;
                        crit   <= CRIT_ONE - CRW'($signed({1'b0, bus.radius}));
                        k      <= '0;
                        busy_q <= 1'b1;
`ifdef CIRCLE_CLEAR_EN
                        clr_x  <= '0;
                        clr_y  <= '0;
                        state  <= ST_CLEAR;
`else
                        state  <= ST_DRAW;
`endif
                    end
                end
`ifdef CIRCLE_CLEAR_EN
                ST_CLEAR: begin
                    vx_q   <= clr_x;
                    vy_q   <= clr_y;
                    vc_q   <= '0;
                    plot_q <= 1'b1;
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        if (clr_y == Y_LAST) begin
                            clr_y <= '0;
                            state <= ST_DRAW;
                        end else begin
                            clr_y <= clr_y + 1'b1;
                        end
                    end else begin
                        clr_x <= clr_x + 1'b1;
                    end
                end
`endif
                ST_DRAW: begin
                    vx_q   <= cand_x;
                    vy_q   <= cand_y;
                    vc_q   <= colour;
                    plot_q <= cand_in;
                    k      <= k + 3'd1;
                    if (k == K_LAST) begin
                        ox   <= ox_nx;
                        oy   <= oy_nx;
                        crit <= crit_nx;
                        if (!more) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.vga_plot   = plot_q;
    assign bus.vga_x      = vx_q;
    assign bus.vga_y      = vy_q;
    assign bus.vga_colour = vc_q;

endmodule

// File: tb/tb_circle_plotter.sv
// Self-checking bench for circle_plotter: table of directed circles plus
// random circles, each compared cycle-by-cycle against a plain-arithmetic
// midpoint model; hand sequences for reset, mid-draw restart and done-cycle start.
`timescale 1ns/1ps
module tb_circle_plotter;
    localparam int H_RES = 160;
    localparam int V_RES = 120;
    localparam int XW = 8, YW = 7, RW = 7, CW = 3;
    localparam int BOUND = 30000;
`ifdef CIRCLE_CLEAR_EN
    localparam int CLR_CYC = H_RES * V_RES;
    localparam int N_RAND  = 0;
`else
    localparam int CLR_CYC = 0;
    localparam int N_RAND  = 8;
`endif

    logic clk = 1'b0;
    logic rst;

    circle_plotter_if #(.XW(XW), .YW(YW), .RW(RW), .CW(CW)) bus_if();

    circle_plotter #(
        .H_RES(H_RES), .V_RES(V_RES), .XW(XW), .YW(YW), .RW(RW), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; bit plot; int col; } pix_t;
    typedef struct { int cx; int cy; int r; int col; int cycles; int repulse; } vec_t;

    pix_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: textbook midpoint circle, eight symmetric points per step.
    task automatic build_model(input int cx, input int cy, input int r, input int col);
        int ox, oy, d;
        int px[8];
        int py[8];
        exp_q.delete();
`ifdef CIRCLE_CLEAR_EN
        for (int yy = 0; yy < V_RES; yy++)
            for (int xx = 0; xx < H_RES; xx++)
                exp_q.push_back('{xx, yy, 1'b1, 0});
`endif
        ox = r; oy = 0; d = 1 - r;
        do begin
            px = '{cx + ox, cx + oy, cx - ox, cx - oy, cx - ox, cx - oy, cx + ox, cx + oy};
            py = '{cy + oy, cy + ox, cy + oy, cy + ox, cy - oy, cy - ox, cy - oy, cy - ox};
            for (int j = 0; j < 8; j++) begin
                bit on;
                on = (px[j] >= 0) && (px[j] < H_RES) && (py[j] >= 0) && (py[j] < V_RES);
                exp_q.push_back('{px[j], py[j], on, col});
            end
            oy = oy + 1;
            if (d <= 0) d = d + 2 * oy + 1;
            else begin
                ox = ox - 1;
                d = d + 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    task automatic run_draw(input vec_t v, input string tag);
        pix_t got[$];
        int   t;
        bit   seen_done;
        build_model(v.cx, v.cy, v.r, v.col);
        @(negedge clk);
        bus_if.start      = 1'b1;
        bus_if.centre_x   = XW'(v.cx);
        bus_if.centre_y   = YW'(v.cy);
        bus_if.radius     = RW'(v.r);
        bus_if.colour_inp = CW'(v.col);
        @(negedge clk);
        bus_if.start = 1'b0;
        chk({tag, " busy-rise"}, int'(bus_if.busy), 1);
        chk({tag, " plot-first"}, int'(bus_if.vga_plot), 0);
        t = 1;
        seen_done = 1'b0;
        while (!seen_done && t < BOUND) begin
            if (v.repulse > 0 && t == v.repulse) begin
                bus_if.start    = 1'b1;
                bus_if.radius   = RW'(20);
                bus_if.centre_x = XW'(40);
            end
            @(negedge clk);
            t++;
            bus_if.start    = 1'b0;
            bus_if.radius   = RW'(v.r);
            bus_if.centre_x = XW'(v.cx);
            if (bus_if.done === 1'b1) seen_done = 1'b1;
            else got.push_back('{int'(bus_if.vga_x), int'(bus_if.vga_y),
                                 bus_if.vga_plot, int'(bus_if.vga_colour)});
        end
        chk({tag, " done-seen"}, int'(seen_done), 1);
        chk({tag, " busy-at-done"}, int'(bus_if.busy), 0);
        chk({tag, " cycles"}, got.size(), exp_q.size());
        if (v.cycles >= 0) chk({tag, " cycles-hand"}, got.size(), v.cycles + CLR_CYC);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s plot[%0d]", tag, i), int'(got[i].plot), int'(exp_q[i].plot));
            if (exp_q[i].plot && got[i].plot)
                chk($sformatf("%s xyc[%0d]", tag, i),
                    got[i].x * 1024 + got[i].y * 8 + got[i].col,
                    exp_q[i].x * 1024 + exp_q[i].y * 8 + exp_q[i].col);
        end
        // a start raised while done is out must not launch a new draw
        bus_if.start  = 1'b1;
        bus_if.radius = RW'(2);
        @(negedge clk);
        bus_if.start = 1'b0;
        chk({tag, " start-in-done busy"}, int'(bus_if.busy), 0);
        chk({tag, " start-in-done done"}, int'(bus_if.done), 0);
        repeat (2) @(negedge clk);
        chk({tag, " start-in-done idle"}, int'(bus_if.busy), 0);
    endtask

    initial begin
        vec_t tab[7];
        vec_t rv;
        bit   done_leak;

        tab[0] = '{80, 60, 0, 5, 8, 0};
        tab[1] = '{80, 60, 1, 3, 16, 0};
        tab[2] = '{0, 0, 5, 7, 32, 0};
        tab[3] = '{80, 60, 10, 2, 64, 20};
        tab[4] = '{159, 119, 5, 1, 32, 0};
        tab[5] = '{100, 50, 10, 6, 64, 0};
        tab[6] = '{30, 40, 3, 4, 24, 0};

        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.centre_x = '0;
        bus_if.centre_y = '0;
        bus_if.radius = '0;
        bus_if.colour_inp = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(bus_if.busy), 0);
        chk("reset done", int'(bus_if.done), 0);
        chk("reset plot", int'(bus_if.vga_plot), 0);
        chk("reset xyc", int'({bus_if.vga_x, bus_if.vga_y, bus_if.vga_colour}), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_draw(tab[i], $sformatf("tab%0d", i));

        for (int i = 0; i < N_RAND; i++) begin
            rv = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                   int'($urandom_range(0, 30)), int'($urandom_range(0, 7)), -1, 0};
            run_draw(rv, $sformatf("rnd%0d", i));
        end

        // reset in the middle of a draw
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.centre_x = XW'(80);
        bus_if.centre_y = YW'(60);
        bus_if.radius = RW'(10);
        bus_if.colour_inp = CW'(7);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (CLR_CYC + 15) @(negedge clk);
        chk("pre-rst busy", int'(bus_if.busy), 1);
        rst = 1'b1;
        #1;
        chk("mid-rst busy", int'(bus_if.busy), 0);
        chk("mid-rst done", int'(bus_if.done), 0);
        chk("mid-rst plot", int'(bus_if.vga_plot), 0);
        chk("mid-rst xyc", int'({bus_if.vga_x, bus_if.vga_y, bus_if.vga_colour}), 0);
        done_leak = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus_if.done !== 1'b0) done_leak = 1'b1;
        end
        rst = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) done_leak = 1'b1;
        end
        chk("mid-rst no done/busy", int'(done_leak), 0);
        run_draw('{30, 40, 3, 4, 24, 0}, "post-rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
